// File: rtl/dmem_arbiter.sv
// Round-robin two-port data memory arbiter/sequencer; DMEM_TIMEOUT_EN adds a BUSY watchdog.
// Latency: req to ready 3 cycles minimum (2 for illegal requests), plus memory wait cycles.
// Backpressure: mem_* held stable until mem_ready; the losing port's req waits in place.
module dmem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [1:0]        p0_size,
   input  logic              p0_sign,
   input  logic [31:0]       p0_wdata,
   output logic              p0_ready,
   output logic [31:0]       p0_rdata,
   output logic              p0_err,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [1:0]        p1_size,
   input  logic              p1_sign,
   input  logic [31:0]       p1_wdata,
   output logic              p1_ready,
   output logic [31:0]       p1_rdata,
   output logic              p1_err,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state;
   logic        last_grant;
   logic        gnt_q;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic              sel_p1;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [1:0]        sel_size;
   logic              sel_sign;
   logic [31:0]       sel_wdata;
   logic [1:0]        sel_off;
   logic              sel_bad;
   logic [3:0]        sel_be;
   logic [31:0]       sel_wlane;
   logic [7:0]        lane8;
   logic [15:0]       lane16;
   logic [31:0]       load_ext;

`ifdef DMEM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
`endif

   // last_grant = 1 means p1 was served last, so p0 wins the next tie
   always_comb begin
      sel_p1    = p1_req && (!p0_req || !last_grant);
      sel_we    = sel_p1 ? p1_we    : p0_we;
      sel_addr  = sel_p1 ? p1_addr  : p0_addr;
      sel_size  = sel_p1 ? p1_size  : p0_size;
      sel_sign  = sel_p1 ? p1_sign  : p0_sign;
      sel_wdata = sel_p1 ? p1_wdata : p0_wdata;
      sel_off   = sel_addr[1:0];
      sel_bad   = 1'b0;
      sel_be    = 4'b1111;
      sel_wlane = sel_wdata;
      case (sel_size)
         2'b01: begin
            sel_be    = 4'b0001 << sel_off;
            sel_wlane = {4{sel_wdata[7:0]}};
         end
         2'b10: begin
            sel_be    = sel_off[1] ? 4'b1100 : 4'b0011;
            sel_wlane = {2{sel_wdata[15:0]}};
            sel_bad   = sel_off[0];
         end
         2'b11:   sel_bad = 1'b1;
         default: sel_bad = (sel_off != 2'b00);
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    lane8 = mem_rdata[7:0];
         2'd1:    lane8 = mem_rdata[15:8];
         2'd2:    lane8 = mem_rdata[23:16];
         default: lane8 = mem_rdata[31:24];
      endcase
      lane16 = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'b01:   load_ext = {{24{sign_q & lane8[7]}}, lane8};
         2'b10:   load_ext = {{16{sign_q & lane16[15]}}, lane16};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_q      <= 1'b0;
         off_q      <= '0;
         size_q     <= '0;
         sign_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         p0_ready   <= 1'b0;
         p0_rdata   <= '0;
         p0_err     <= 1'b0;
         p1_ready   <= 1'b0;
         p1_rdata   <= '0;
         p1_err     <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
`ifdef DMEM_TIMEOUT_EN
         to_cnt     <= '0;
`endif
      end else begin
         p0_ready <= 1'b0;
         p0_rdata <= '0;
         p0_err   <= 1'b0;
         p1_ready <= 1'b0;
         p1_rdata <= '0;
         p1_err   <= 1'b0;
         case (state)
            IDLE: begin
               // While a ready pulse is out the finished request is still on req; skip it
               if ((p0_req || p1_req) && !p0_ready && !p1_ready) begin
                  gnt_q      <= sel_p1;
                  last_grant <= sel_p1;
                  off_q      <= sel_off;
                  size_q     <= sel_size;
                  sign_q     <= sel_sign;
                  if (sel_bad) begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                     state   <= RESP;
                  end else begin
                     err_q     <= 1'b0;
                     mem_valid <= 1'b1;
                     mem_we    <= sel_we;
                     mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                     mem_be    <= sel_be;
                     mem_wdata <= sel_wlane;
                     state     <= BUSY;
`ifdef DMEM_TIMEOUT_EN
                     to_cnt    <= '0;
`endif
                  end
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  rdata_q   <= mem_we ? 32'd0 : load_ext;
                  state     <= RESP;
               end
`ifdef DMEM_TIMEOUT_EN
               else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  mem_valid <= 1'b0;
                  err_q     <= 1'b1;
                  rdata_q   <= '0;
                  state     <= RESP;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            RESP: begin
               if (gnt_q) begin
                  p1_ready <= 1'b1;
                  p1_rdata <= rdata_q;
                  p1_err   <= err_q;
               end else begin
                  p0_ready <= 1'b1;
                  p0_rdata <= rdata_q;
                  p0_err   <= err_q;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and random transactions against a word-array memory model.
// Latency, lane/extension results, arbitration order and reset behaviour are checked inline.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p0_sign, p0_ready, p0_err;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic [1:0]  p0_size;
   logic        p1_req, p1_we, p1_sign, p1_ready, p1_err;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic [1:0]  p1_size;
   logic        mem_valid, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem_model [0:127];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
      .p0_sign(p0_sign), .p0_wdata(p0_wdata), .p0_ready(p0_ready),
      .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
      .p1_sign(p1_sign), .p1_wdata(p1_wdata), .p1_ready(p1_ready),
      .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference load result: pick the addressed byte/half arithmetically, then extend
   function automatic logic [31:0] exp_load(input logic [31:0] w, input int off,
                                            input logic [1:0] size, input bit sign);
      logic [31:0] v;
      case (size)
         2'd1: begin
            v = (w >> (8 * off)) % 256;
            if (sign && v >= 128) v = v + 32'hFFFFFF00;
         end
         2'd2: begin
            v = (w >> (16 * (off / 2))) % 65536;
            if (sign && v >= 32768) v = v + 32'hFFFF0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   task automatic set_port(input int port, input bit req, input bit we, input logic [31:0] addr,
                           input logic [1:0] size, input bit sign, input logic [31:0] wdata);
      if (port == 0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_sign = sign; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_sign = sign; p1_wdata = wdata;
      end
   endtask

   // Memory side of one cycle: respond when busy, otherwise drive noise that must be ignored
   task automatic mem_respond(input bit rdy);
      if (mem_valid) begin
         mem_ready = rdy;
         mem_rdata = mem_model[mem_addr[8:2]];
         if (rdy && mem_we)
            for (int i = 0; i < 4; i++)
               if (mem_be[i]) mem_model[mem_addr[8:2]][8*i +: 8] = mem_wdata[8*i +: 8];
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
      end
   endtask

   task automatic do_txn(input int port, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit sign, input logic [31:0] wdata,
                         input int delay);
      bit          bad, done;
      logic [3:0]  be;
      logic [31:0] lanes, exp_rd;
      int          off, idx, cyc, busy, exp_lat;
      off = int'(addr % 4);
      idx = int'((addr / 4) % 128);
      bad = (size == 2'd3) || (size == 2'd2 && off % 2 != 0) || (size == 2'd0 && off != 0);
      case (size)
         2'd1:    begin be = 4'(1 << off);                  lanes = wdata[7:0] * 32'h01010101;  end
         2'd2:    begin be = (off >= 2) ? 4'hC : 4'h3;       lanes = wdata[15:0] * 32'h00010001; end
         default: begin be = 4'hF;                          lanes = wdata;                      end
      endcase
      exp_rd  = (bad || we) ? 32'd0 : exp_load(mem_model[idx], off, size, sign);
      exp_lat = bad ? 2 : 3 + delay;
      set_port(port, 1'b1, we, addr, size, sign, wdata);
      cyc = 0; busy = 0; done = 0;
      while (!done && cyc < 60) begin
         tick;
         cyc++;
         if (bad) check("illegal_mem_valid", {31'd0, mem_valid}, 32'd0);
         if (mem_valid) begin
            busy++;
            check("mem_we", {31'd0, mem_we}, {31'd0, we});
            check("mem_addr", mem_addr, addr - 32'(off));
            check("mem_be", {28'd0, mem_be}, {28'd0, be});
            if (we) check("mem_wdata", mem_wdata, lanes);
         end
         mem_respond(busy > delay);
         if (port == 0) begin
            check("other_ready", {31'd0, p1_ready}, 32'd0);
            if (p0_ready) begin
               check("latency", 32'(cyc), 32'(exp_lat));
               check("rdata", p0_rdata, exp_rd);
               check("err", {31'd0, p0_err}, {31'd0, bad});
               done = 1;
            end
         end else begin
            check("other_ready", {31'd0, p0_ready}, 32'd0);
            if (p1_ready) begin
               check("latency", 32'(cyc), 32'(exp_lat));
               check("rdata", p1_rdata, exp_rd);
               check("err", {31'd0, p1_err}, {31'd0, bad});
               done = 1;
            end
         end
      end
      if (!done) check("txn_timeout", {31'd0, (port == 0) ? p0_ready : p1_ready}, 32'd1);
      set_port(port, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
      mem_ready = 1'b0;
      tick;
      check("ready_pulse", {31'd0, (port == 0) ? p0_ready : p1_ready}, 32'd0);
      check("rdata_idle", (port == 0) ? p0_rdata : p1_rdata, 32'd0);
   endtask

   initial begin
      int          n, grants, exp_next, cyc;
      bit          prev0, prev1;
      logic [31:0] exp0, exp1;

      for (int i = 0; i < 128; i++) mem_model[i] = $urandom;
      rst = 1'b1;
      set_port(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
      set_port(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      repeat (3) tick;
      check("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
      check("rst_p1_ready", {31'd0, p1_ready}, 32'd0);
      check("rst_p0_rdata", p0_rdata, 32'd0);
      check("rst_p1_rdata", p1_rdata, 32'd0);
      check("rst_errs", {30'd0, p0_err, p1_err}, 32'd0);
      check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_mem_fields", {mem_addr[27:0], mem_be} | mem_wdata | {31'd0, mem_we}, 32'd0);
      rst = 1'b0;
      tick;

      // Directed: signed/unsigned byte load, half store and readback, illegal forms, slow memory
      mem_model[64] = 32'h80123456;
      do_txn(0, 1'b0, 32'h103, 2'b01, 1'b1, 32'd0, 0);
      do_txn(0, 1'b0, 32'h103, 2'b01, 1'b0, 32'd0, 0);
      do_txn(1, 1'b1, 32'h022, 2'b10, 1'b0, 32'h0000BEEF, 0);
      do_txn(0, 1'b0, 32'h020, 2'b00, 1'b0, 32'd0, 1);
      do_txn(0, 1'b0, 32'h102, 2'b00, 1'b0, 32'd0, 0);
      do_txn(1, 1'b0, 32'h044, 2'b11, 1'b1, 32'd0, 0);
      do_txn(1, 1'b1, 32'h047, 2'b10, 1'b0, 32'h12345678, 0);
      do_txn(0, 1'b0, 32'h044, 2'b00, 1'b0, 32'd0, 0);
      do_txn(1, 1'b0, 32'h086, 2'b10, 1'b1, 32'd0, 5);
      do_txn(0, 1'b1, 32'h0C8, 2'b00, 1'b0, 32'hCAFEF00D, 12);
      do_txn(1, 1'b0, 32'h0C9, 2'b01, 1'b1, 32'd0, 2);

      for (int i = 0; i < 40; i++)
         do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 4));

      // Reset while p0 is held in BUSY: request dropped, no pulse, p0 wins the next tie
      mem_ready = 1'b0;
      set_port(0, 1'b1, 1'b0, 32'h010, 2'b00, 1'b0, 32'd0);
      n = 0;
      while (!mem_valid && n < 10) begin tick; n++; end
      check("rst_busy_valid", {31'd0, mem_valid}, 32'd1);
      repeat (3) begin
         tick;
         check("busy_hold", {31'd0, mem_valid}, 32'd1);
         check("busy_addr", mem_addr, 32'h010);
      end
      rst = 1'b1;
      set_port(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
      tick;
      check("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_mid_ready", {30'd0, p0_ready, p1_ready}, 32'd0);
      rst = 1'b0;
      repeat (4) begin
         tick;
         check("post_rst_quiet", {29'd0, mem_valid, p0_ready, p1_ready}, 32'd0);
      end

      // Both ports requesting continuously: strict alternation starting at p0
      exp0 = exp_load(mem_model[16], 0, 2'b00, 1'b0);
      exp1 = exp_load(mem_model[17], 1, 2'b01, 1'b1);
      set_port(0, 1'b1, 1'b0, 32'h040, 2'b00, 1'b0, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'h045, 2'b01, 1'b1, 32'd0);
      exp_next = 0; grants = 0; prev0 = 0; prev1 = 0; cyc = 0;
      while (grants < 8 && cyc < 300) begin
         tick;
         cyc++;
         check("both_ready", {31'd0, p0_ready & p1_ready}, 32'd0);
         check("p0_single_pulse", {31'd0, p0_ready & prev0}, 32'd0);
         check("p1_single_pulse", {31'd0, p1_ready & prev1}, 32'd0);
         prev0 = p0_ready;
         prev1 = p1_ready;
         if (p0_ready || p1_ready) begin
            check("alt_order", {31'd0, p1_ready}, 32'(exp_next));
            if (p0_ready) check("alt_p0_rdata", p0_rdata, exp0);
            else          check("alt_p1_rdata", p1_rdata, exp1);
            exp_next = 1 - exp_next;
            grants++;
         end
         mem_respond(1'($urandom_range(0, 1)));
      end
      check("alt_grants", 32'(grants), 32'd8);
      set_port(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
      set_port(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
      mem_ready = 1'b0;
      repeat (3) tick;
      check("final_idle", {29'd0, mem_valid, p0_ready, p1_ready}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
